sfx_chime_sequencer: RTL and testbench
======================================

// Module: sfx_chime_sequencer
// PURPOSE
//  Event-driven sound-effect engine that replaces the single-tone jump/land beeper.
//  Takes NUM_EVENTS toggle events from the game-logic (pixel) clock domain and synchronises them.
//  Queues simultaneous events by priority and plays each as a two-note chime (note A, then optional note B).
//  Outputs signed square-wave samples for the I2S speaker controller.
// PARAMETERS
//  NUM_EVENTS  4    number of event inputs; index 0 has the highest priority
//  DIV_W       22   width of the half-period divider (clk cycles per phase)
//  DUR_W       26   width of the per-note duration counter (clk cycles)
//  AMP_W       16   sample width, two's complement
//  AMP_STEP    200  amplitude per volume step; 7*AMP_STEP must be < 2^(AMP_W-1)
// PORTS
//  clk          in   1                 system clock; the block's only clock
//  rst_n        in   1                 asynchronous, active-low reset
//  ev_toggle    in   NUM_EVENTS        event toggles from another domain; any level change = 1 event
//  ev_div_a     in   NUM_EVENTS*DIV_W  per-event note-A half-period; slice i = event i; 0 = rest
//  ev_div_b     in   NUM_EVENTS*DIV_W  per-event note-B half-period; 0 = no second note
//  ev_dur       in   NUM_EVENTS*DUR_W  per-event duration of each note, in cycles; 0 treated as 1
//  volume       in   3                 0..7; 0 = silent
//  mute         in   1                 forces samples to 0; sequencing continues
//  audio_left   out  AMP_W             signed sample
//  audio_right  out  AMP_W             signed sample; equals audio_left
//  busy         out  1                 high while a chime is playing
//  cur_event    out  clog2(NUM_EVENTS) index of the playing event; holds its last value when idle
// BEHAVIOUR
//  - Reset (rst_n=0): sync flops, pending, counters and phase clear. State = IDLE.
//    audio_*=0, busy=0, cur_event=0. The sync flops reset to 0, so a toggle input sitting at 1 when
//    reset releases is detected as one event after release.
//  - Sync/detect: 2-FF synchroniser, then a previous-value flop per bit. A change sets pending[i].
//    Two toggles closer together than 3 clk cycles may merge into one event (documented limitation).
//  - Pending bits are sticky until the event is serviced. Re-triggering a pending event does not
//    queue a second copy.
//  - Selection: lowest-index pending bit wins. Ties from simultaneous events resolve the same way;
//    the rest stay pending and play back-to-back afterwards.
//  - Preemption:
//      - A newly detected event with index <= cur_event aborts the current chime and restarts PLAY_A
//        with the new event.
//      - Same-index retrigger restarts the chime.
//      - A lower-priority event only queues.
//  - Load: the selected event's div_a/div_b/dur are captured into registers when entering PLAY_A.
//    Later changes on the table inputs do not affect a chime already in progress.
//  - FSM:
//      IDLE   -> PLAY_A when any pending bit is set. Clear that bit, capture its parameters.
//      PLAY_A -> PLAY_B when the duration counter expires and div_b != 0; otherwise -> NEXT.
//      PLAY_B -> NEXT when the duration counter expires.
//      NEXT   -> PLAY_A if any bit is still pending; otherwise -> IDLE.
//  - Duration counter: loads dur-1 on entry to PLAY_A and PLAY_B and decrements to 0.
//    Each note lasts exactly max(dur,1) cycles.
//  - Oscillator:
//      - Phase counter runs 0..div-1; the square phase toggles when the count wraps.
//      - Counter and phase reset to 0 on every note entry.
//      - div == 0 holds the phase, and the sample is 0 (rest).
//  - Sample = phase ? +volume*AMP_STEP : -volume*AMP_STEP, registered.
//    Sample is 0 when IDLE, NEXT, rest, mute=1 or volume=0.
//  - Latency: an ev_toggle edge at cycle 0 gives pending at cycle 3, busy=1 at cycle 4, and the first
//    nonzero sample at cycle 5.
//  - busy=1 in PLAY_A, PLAY_B and NEXT, and 0 only in IDLE.
//  - cur_event updates on entry to PLAY_A.
// STRUCTURE
//  - Shared header sfx_defs.vh holds the FSM state encodings (IDLE, PLAY_A, PLAY_B, NEXT) and the
//    default AMP_STEP.
//  - Sub-module sfx_square_osc: div, restart strobe and enable in; phase out.
//    Instantiated once and reused across notes.
//  - The priority encoder and synchroniser are inline.
// TESTING (NUM_EVENTS=4, volume=5, AMP_STEP=200)
//  1. ev0 div_a=4, div_b=0, dur=20; toggle ev_toggle[0] once.
//     -> busy for 21 cycles (PLAY_A + NEXT); samples alternate -1000/+1000 every 4 cycles; then 0 and idle.
//  2. ev1 div_a=4, div_b=2, dur=10.
//     -> 10 cycles with period 8, then 10 cycles with period 4; the phase restarts at 0 on the note-B boundary.
//  3. Toggle ev3 and ev1 in the same cycle.
//     -> cur_event=1 plays first; ev3 follows with no IDLE cycle between them.
//  4. ev2 playing; toggle ev0 mid-note -> ev0 starts 4 cycles later and ev2 is dropped.
//     ev0 playing; toggle ev2 -> ev2 plays after ev0.
//  5. Assert mute (or volume=0) mid-chime -> samples 0 while busy and the timing is unchanged.
//     Deassert rst_n mid-chime -> busy=0 and all samples 0 immediately; no event is replayed after release.

Source files
------------

// File: rtl/sfx_chime_sequencer_pkg.sv
// Shared types and defaults for the chime sequencer.
package sfx_chime_sequencer_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StPlayA = 2'd1,
    StPlayB = 2'd2,
    StNext  = 2'd3
  } sfx_state_e;

  localparam int unsigned DefaultAmpStep = 200;

endpackage

// File: rtl/sfx_chime_sequencer_square_osc.sv
// Square-wave phase generator; the phase flips every div_i enabled cycles.
module sfx_chime_sequencer_square_osc #(
  parameter int unsigned DivW = 22
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [DivW-1:0] div_i,
  input  logic            restart_i,
  input  logic            en_i,
  output logic            phase_o
);

  logic [DivW-1:0] cnt_q, cnt_d;
  logic            phase_q, phase_d;

  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (restart_i) begin
      cnt_d   = '0;
      phase_d = 1'b0;
    end else if (en_i && (div_i != '0)) begin
      // >= rather than == keeps the counter bounded if div_i ever shrinks
      if (cnt_q >= div_i - DivW'(1)) begin
        cnt_d   = '0;
        phase_d = ~phase_q;
      end else begin
        cnt_d = cnt_q + DivW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  assign phase_o = phase_q;

endmodule

// File: rtl/sfx_chime_sequencer.sv
// Event-driven two-note chime player: synchronised toggle events, priority queue, square samples.
module sfx_chime_sequencer
  import sfx_chime_sequencer_pkg::*;
#(
  parameter int unsigned NUM_EVENTS = 4,
  parameter int unsigned DIV_W      = 22,
  parameter int unsigned DUR_W      = 26,
  parameter int unsigned AMP_W      = 16,
  parameter int unsigned AMP_STEP   = DefaultAmpStep,
  localparam int unsigned EvW       = (NUM_EVENTS > 1) ? $clog2(NUM_EVENTS) : 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_EVENTS-1:0]         ev_toggle,
  input  logic [NUM_EVENTS*DIV_W-1:0]   ev_div_a,
  input  logic [NUM_EVENTS*DIV_W-1:0]   ev_div_b,
  input  logic [NUM_EVENTS*DUR_W-1:0]   ev_dur,
  input  logic [2:0]                    volume,
  input  logic                          mute,
  output logic signed [AMP_W-1:0]       audio_left,
  output logic signed [AMP_W-1:0]       audio_right,
  output logic                          busy,
  output logic [EvW-1:0]                cur_event
);

  logic [NUM_EVENTS-1:0] sync1_q, sync2_q, prev_q, new_q;
  logic [NUM_EVENTS-1:0] pend_q, pend_d, det, clr;

  logic [DIV_W-1:0] div_a_tbl [NUM_EVENTS];
  logic [DIV_W-1:0] div_b_tbl [NUM_EVENTS];
  logic [DUR_W-1:0] dur_tbl   [NUM_EVENTS];

  sfx_state_e       state_q, state_d;
  logic [EvW-1:0]   cur_event_q, cur_event_d, sel_idx;
  logic [DIV_W-1:0] div_a_q, div_a_d, div_b_q, div_b_d, div_cur;
  logic [DUR_W-1:0] dur_q, dur_d, dur_cnt_q, dur_cnt_d, dur_sel;
  logic             load, to_b, preempt, playing, phase, note_on;
  logic [AMP_W-1:0] mag, sample_q, sample_d;

  assign det = sync2_q ^ prev_q;

  always_comb begin
    for (int i = 0; i < int'(NUM_EVENTS); i++) begin
      div_a_tbl[i] = ev_div_a[i*DIV_W +: DIV_W];
      div_b_tbl[i] = ev_div_b[i*DIV_W +: DIV_W];
      dur_tbl[i]   = ev_dur[i*DUR_W +: DUR_W];
    end
  end

  // Scan downwards so the lowest pending index wins.
  always_comb begin
    sel_idx = '0;
    for (int i = int'(NUM_EVENTS) - 1; i >= 0; i--) begin
      if (pend_q[i]) sel_idx = EvW'(i);
    end
  end

  always_comb begin
    preempt = 1'b0;
    for (int i = 0; i < int'(NUM_EVENTS); i++) begin
      if (new_q[i] && (EvW'(i) <= cur_event_q)) preempt = 1'b1;
    end
  end

  assign playing = (state_q == StPlayA) || (state_q == StPlayB);
  assign dur_sel = dur_tbl[sel_idx];

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    to_b    = 1'b0;
    unique case (state_q)
      StIdle: load = |pend_q;
      StPlayA, StPlayB: begin
        if (preempt) begin
          load = 1'b1;
        end else if (dur_cnt_q == '0) begin
          if ((state_q == StPlayA) && (div_b_q != '0)) to_b = 1'b1;
          else state_d = StNext;
        end
      end
      StNext: begin
        if (|pend_q) load = 1'b1;
        else state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (load) state_d = StPlayA;
    if (to_b) state_d = StPlayB;
  end

  always_comb begin
    clr         = load ? (NUM_EVENTS'(1) << sel_idx) : '0;
    pend_d      = (pend_q & ~clr) | det;
    cur_event_d = cur_event_q;
    div_a_d     = div_a_q;
    div_b_d     = div_b_q;
    dur_d       = dur_q;
    dur_cnt_d   = dur_cnt_q;
    if (load) begin
      cur_event_d = sel_idx;
      div_a_d     = div_a_tbl[sel_idx];
      div_b_d     = div_b_tbl[sel_idx];
      dur_d       = dur_sel;
      dur_cnt_d   = (dur_sel == '0) ? '0 : dur_sel - DUR_W'(1);
    end else if (to_b) begin
      dur_cnt_d = (dur_q == '0) ? '0 : dur_q - DUR_W'(1);
    end else if (playing && (dur_cnt_q != '0)) begin
      dur_cnt_d = dur_cnt_q - DUR_W'(1);
    end
  end

  assign div_cur = (state_q == StPlayB) ? div_b_q : div_a_q;

  sfx_chime_sequencer_square_osc #(
    .DivW (DIV_W)
  ) u_osc (
    .clk       (clk),
    .rst_n     (rst_n),
    .div_i     (div_cur),
    .restart_i (load | to_b),
    .en_i      (playing),
    .phase_o   (phase)
  );

  assign note_on  = playing && (div_cur != '0) && !mute && (volume != 3'd0);
  assign mag      = AMP_W'(volume * AMP_STEP);
  assign sample_d = note_on ? (phase ? mag : -mag) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      prev_q      <= '0;
      new_q       <= '0;
      pend_q      <= '0;
      state_q     <= StIdle;
      cur_event_q <= '0;
      div_a_q     <= '0;
      div_b_q     <= '0;
      dur_q       <= '0;
      dur_cnt_q   <= '0;
      sample_q    <= '0;
    end else begin
      sync1_q     <= ev_toggle;
      sync2_q     <= sync1_q;
      prev_q      <= sync2_q;
      new_q       <= det;
      pend_q      <= pend_d;
      state_q     <= state_d;
      cur_event_q <= cur_event_d;
      div_a_q     <= div_a_d;
      div_b_q     <= div_b_d;
      dur_q       <= dur_d;
      dur_cnt_q   <= dur_cnt_d;
      sample_q    <= sample_d;
    end
  end

  assign audio_left  = sample_q;
  assign audio_right = sample_q;
  assign busy        = (state_q != StIdle);
  assign cur_event   = cur_event_q;

endmodule

// File: tb/tb_sfx_chime_sequencer.sv
// Bench for sfx_chime_sequencer: chime-level reference model, per-cycle compare, directed pins.
module tb_sfx_chime_sequencer;

  localparam int NE   = 4;
  localparam int DW   = 22;
  localparam int UW   = 26;
  localparam int STEP = 200;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NE-1:0]     ev_toggle;
  logic [NE*DW-1:0]  ev_div_a, ev_div_b;
  logic [NE*UW-1:0]  ev_dur;
  logic [2:0]        volume;
  logic              mute;
  logic signed [15:0] audio_left, audio_right;
  logic              busy;
  logic [1:0]        cur_event;

  int errors = 0;
  int checks = 0;

  sfx_chime_sequencer #(
    .NUM_EVENTS (NE),
    .DIV_W      (DW),
    .DUR_W      (UW),
    .AMP_W      (16),
    .AMP_STEP   (STEP)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ev_toggle   (ev_toggle),
    .ev_div_a    (ev_div_a),
    .ev_div_b    (ev_div_b),
    .ev_dur      (ev_dur),
    .volume      (volume),
    .mute        (mute),
    .audio_left  (audio_left),
    .audio_right (audio_right),
    .busy        (busy),
    .cur_event   (cur_event)
  );

  always #5 clk = ~clk;

  // Reference model: a chime is (event, note, cycles elapsed in that note).
  // m_note: -1 nothing playing, 0 note A, 1 note B, 2 one-cycle gap between chimes.
  int        m_note = -1;
  int        m_elapsed = 0;
  int        m_ev = 0;
  int        m_len = 1;
  int        m_div [2];
  bit [NE-1:0] m_seen [3];
  bit [NE-1:0] m_fresh = '0;
  bit [NE-1:0] m_pend = '0;
  int        m_busy = 0;
  int        m_cur = 0;
  int        m_audio = 0;

  always @(posedge clk) begin
    bit [NE-1:0] arrived;
    bit          preempt, done, start;
    int          sel, dv, smp, d;
    if (!rst_n) begin
      m_note = -1; m_elapsed = 0; m_ev = 0; m_len = 1;
      m_seen[0] = '0; m_seen[1] = '0; m_seen[2] = '0;
      m_fresh = '0; m_pend = '0;
      m_busy = 0; m_cur = 0; m_audio = 0;
    end else begin
      arrived = m_seen[1] ^ m_seen[2];
      preempt = 1'b0;
      if (m_note == 0 || m_note == 1)
        for (int i = 0; i <= m_ev; i++) if (m_fresh[i]) preempt = 1'b1;
      smp = 0;
      if (m_note == 0 || m_note == 1) begin
        dv = m_div[m_note];
        if (dv != 0 && !mute && volume != 3'd0)
          smp = (((m_elapsed / dv) % 2) == 1) ? int'(volume) * STEP : -(int'(volume) * STEP);
      end
      done  = (m_note == 0 || m_note == 1) && (m_elapsed + 1 >= m_len);
      start = preempt || ((m_note == -1 || m_note == 2) && m_pend != '0);
      if (start) begin
        sel = 0;
        for (int i = NE - 1; i >= 0; i--) if (m_pend[i]) sel = i;
        m_pend[sel] = 1'b0;
        m_note = 0; m_elapsed = 0; m_ev = sel;
        m_div[0] = int'(ev_div_a[sel*DW +: DW]);
        m_div[1] = int'(ev_div_b[sel*DW +: DW]);
        d = int'(ev_dur[sel*UW +: UW]);
        m_len = (d == 0) ? 1 : d;
      end else if (done) begin
        if (m_note == 0 && m_div[1] != 0) begin
          m_note = 1; m_elapsed = 0;
        end else begin
          m_note = 2;
        end
      end else if (m_note == 2) begin
        m_note = -1;
      end else if (m_note >= 0) begin
        m_elapsed++;
      end
      m_pend  = m_pend | arrived;
      m_fresh = arrived;
      m_seen[2] = m_seen[1];
      m_seen[1] = m_seen[0];
      m_seen[0] = ev_toggle;
      m_busy  = (m_note != -1) ? 1 : 0;
      m_cur   = m_ev;
      m_audio = smp;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic compare_loop();
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        check("rst_busy", int'(busy), 0);
        check("rst_audio", int'(audio_left), 0);
        check("rst_cur", int'(cur_event), 0);
      end else begin
        check("model_busy", int'(busy), m_busy);
        check("model_cur", int'(cur_event), m_cur);
        check("model_left", int'(audio_left), m_audio);
        check("model_right", int'(audio_right), m_audio);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic set_ev(input int i, input int a, input int b, input int d);
    ev_div_a[i*DW +: DW] = DW'(a);
    ev_div_b[i*DW +: DW] = DW'(b);
    ev_dur[i*UW +: UW]   = UW'(d);
  endtask

  task automatic flip(input int i);
    ev_toggle[i] = ~ev_toggle[i];
  endtask

  initial begin
    rst_n = 1'b0; ev_toggle = '0; ev_div_a = '0; ev_div_b = '0; ev_dur = '0;
    volume = 3'd5; mute = 1'b0;
    fork
      compare_loop();
    join_none
    ticks(3);
    check("reset_busy", int'(busy), 0);
    check("reset_audio", int'(audio_left), 0);
    rst_n = 1'b1;

    // Single-note chime: 20 cycles of period 8 then one gap cycle.
    set_ev(0, 4, 0, 20);
    flip(0);
    ticks(3);  check("t1_busy_c3", int'(busy), 0);
    tick();    check("t1_busy_c4", int'(busy), 1);
               check("t1_audio_c4", int'(audio_left), 0);
    tick();    check("t1_audio_c5", int'(audio_left), -1000);
    ticks(4);  check("t1_audio_c9", int'(audio_left), 1000);
    ticks(15); check("t1_busy_c24", int'(busy), 1);
               check("t1_audio_c24", int'(audio_left), -1000);
    tick();    check("t1_busy_c25", int'(busy), 0);
               check("t1_audio_c25", int'(audio_left), 0);
    ticks(5);

    // Two-note chime; note B restarts at phase 0.
    set_ev(1, 4, 2, 10);
    flip(1);
    ticks(12); check("t2_audio_c12", int'(audio_left), 1000);
    ticks(3);  check("t2_audio_c15", int'(audio_left), -1000);
    ticks(2);  check("t2_audio_c17", int'(audio_left), 1000);
    ticks(30);

    // Simultaneous ev3 + ev1: ev1 first, ev3 straight after the gap cycle.
    set_ev(3, 3, 0, 6);
    flip(3); flip(1);
    ticks(4);  check("t3_cur_first", int'(cur_event), 1);
    ticks(21); check("t3_cur_second", int'(cur_event), 3);
               check("t3_busy_second", int'(busy), 1);
    ticks(20);

    // ev0 preempts ev2, and ev2 is dropped.
    set_ev(2, 5, 0, 30);
    flip(2);
    ticks(10);
    flip(0);
    ticks(3);  check("t4_cur_before", int'(cur_event), 2);
    tick();    check("t4_cur_preempt", int'(cur_event), 0);
    ticks(21); check("t4_dropped", int'(busy), 0);
    ticks(5);
    // ev2 arriving during ev0 waits its turn.
    flip(0);
    ticks(8);
    flip(2);
    ticks(16); check("t4_cur_ev0", int'(cur_event), 0);
    tick();    check("t4_cur_queued", int'(cur_event), 2);
    ticks(40);

    // Mute mid-chime.
    flip(1);
    ticks(8);
    mute = 1'b1;
    tick();    check("t5_mute_audio", int'(audio_left), 0);
               check("t5_mute_busy", int'(busy), 1);
    ticks(5);
    mute = 1'b0;
    ticks(40);

    // Returning toggles to 0 queues ev0, ev1, ev3; reset mid-chime discards all of them.
    ev_toggle = '0;
    ticks(10);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_rst_busy", int'(busy), 0);
    check("t5_rst_audio", int'(audio_left), 0);
    ticks(2);
    rst_n = 1'b1;
    ticks(40); check("t5_no_replay", int'(busy), 0);

    // Randomised traffic against the model.
    for (int i = 0; i < NE; i++)
      set_ev(i, $urandom_range(0, 6), $urandom_range(0, 5), $urandom_range(0, 12));
    for (int c = 0; c < 2000; c++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 6) flip($urandom_range(0, NE - 1));
      else if (r < 8) ev_toggle = ev_toggle ^ NE'($urandom_range(1, 15));
      else if (r < 11)
        set_ev($urandom_range(0, NE - 1), $urandom_range(0, 6), $urandom_range(0, 5),
               $urandom_range(0, 12));
      else if (r == 11) volume = 3'($urandom_range(0, 7));
      else if (r == 12) mute = ($urandom_range(0, 3) == 0);
      else if (r == 13 && $urandom_range(0, 7) == 0) begin
        rst_n = 1'b0;
        ticks(2);
        rst_n = 1'b1;
      end
      tick();
    end
    mute = 1'b0;
    ticks(60);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
